// File: rtl/axi_ar_rr_arbiter.sv
// axi_ar_rr_arbiter
//   Per-initiator-port AR channel arbiter. It takes the arvalid requests that the
//   per-target AR decoders steer at one initiator port and picks one by round-robin.
//   The winner's payload and valid go to the initiator port, and arready is routed
//   back to the winning target.
//
// Parameters
//   N_TARG_PORT    number of requesting target ports (>=1)
//   AR_DATA_WIDTH  width of the packed AR payload
//   ID_WIDTH       width of the grant index, $clog2(N_TARG_PORT) with a minimum of 1
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   arvalid_i  in   per-target AR request
//   ardata_i   in   per-target packed payload, target t at [t*W +: W]
//   arready_o  out  per-target AR accept, one-hot or zero
//   arvalid_o  out  AR valid toward the initiator port
//   ardata_o   out  payload of the granted target
//   arid_o     out  index of the granted target (used for R routing)
//   arready_i  in   initiator port AR ready
//
// Configuration
//   AXI_AR_ARB_OUT_REG_EN  when defined, a single-entry output register drives
//                          arvalid_o/ardata_o/arid_o (1-cycle latency, 1 AR/cycle).
//                          When undefined, the path is combinational with a grant
//                          lock that holds the winner while the initiator stalls.

module axi_ar_rr_arbiter #(
    parameter int unsigned N_TARG_PORT   = 8,
    parameter int unsigned AR_DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH      = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_TARG_PORT-1:0]               arvalid_i,
    input  logic [N_TARG_PORT*AR_DATA_WIDTH-1:0] ardata_i,
    output logic [N_TARG_PORT-1:0]               arready_o,
    output logic                                 arvalid_o,
    output logic [AR_DATA_WIDTH-1:0]             ardata_o,
    output logic [ID_WIDTH-1:0]                  arid_o,
    input  logic                                 arready_i
);

    logic [ID_WIDTH-1:0]      r_rr;
    logic [ID_WIDTH-1:0]      w_rr_grant;
    logic                     w_rr_found;
    logic [ID_WIDTH-1:0]      w_grant;
    logic [ID_WIDTH-1:0]      w_grant_inc;
    logic                     w_sel_valid;
    logic [AR_DATA_WIDTH-1:0] w_sel_data;
    logic                     w_accept;

    // Round-robin search starting at r_rr: the first pass looks at indices >= r_rr,
    // the second pass (only reached when the first finds nothing) wraps to the
    // lowest requester overall.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        for (int unsigned t = 0; t < N_TARG_PORT; t++) begin
            if (!w_rr_found && arvalid_i[t] && (ID_WIDTH'(t) >= r_rr)) begin
                w_rr_found = 1'b1;
                w_rr_grant = ID_WIDTH'(t);
            end
        end
        for (int unsigned t = 0; t < N_TARG_PORT; t++) begin
            if (!w_rr_found && arvalid_i[t]) begin
                w_rr_found = 1'b1;
                w_rr_grant = ID_WIDTH'(t);
            end
        end
    end

    // Payload/valid mux for the current grant. With no requester the unlocked
    // grant is 0 and arvalid_i[0] is low, so w_sel_valid doubles as "any request".
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int unsigned t = 0; t < N_TARG_PORT; t++) begin
            if (ID_WIDTH'(t) == w_grant) begin
                w_sel_valid = arvalid_i[t];
                w_sel_data  = ardata_i[t*AR_DATA_WIDTH +: AR_DATA_WIDTH];
            end
        end
    end

    assign w_grant_inc = (w_grant == ID_WIDTH'(N_TARG_PORT - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        arready_o = '0;
        for (int unsigned t = 0; t < N_TARG_PORT; t++) begin
            arready_o[t] = w_accept & (ID_WIDTH'(t) == w_grant);
        end
    end

`ifdef AXI_AR_ARB_OUT_REG_EN

    logic                     r_valid;
    logic [AR_DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]      r_id;
    logic                     w_load;

    // The output register holds the payload stable on its own, so no lock is needed.
    assign w_grant  = w_rr_grant;
    assign w_load   = ~r_valid | arready_i;
    assign w_accept = ~rst & w_load & w_sel_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_rr    <= '0;
        end else if (w_load) begin
            r_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_data <= w_sel_data;
                r_id   <= w_grant;
                r_rr   <= w_grant_inc;
            end
        end
    end

    assign arvalid_o = r_valid & ~rst;
    assign ardata_o  = r_data;
    assign arid_o    = r_id;

`else

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t         r_state;
    lock_state_t         w_state_nxt;
    logic [ID_WIDTH-1:0] r_lock_idx;
    logic [ID_WIDTH-1:0] w_lock_idx_nxt;
    logic [ID_WIDTH-1:0] w_rr_nxt;
    logic                w_xfer;

    // While locked the stalled winner keeps the grant, so its payload stays stable.
    assign w_grant  = (r_state == ST_LOCKED) ? r_lock_idx : w_rr_grant;
    assign w_xfer   = w_sel_valid & arready_i;
    assign w_accept = ~rst & w_xfer;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_rr_nxt       = r_rr;
        if (w_xfer) begin
            w_state_nxt = ST_OPEN;
            w_rr_nxt    = w_grant_inc;
        end else if (w_sel_valid) begin
            w_state_nxt    = ST_LOCKED;
            w_lock_idx_nxt = w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OPEN;
            r_lock_idx <= '0;
            r_rr       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_rr       <= w_rr_nxt;
        end
    end

    assign arvalid_o = w_sel_valid & ~rst;
    assign ardata_o  = w_sel_data;
    assign arid_o    = w_grant;

`endif

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Testbench for axi_ar_rr_arbiter (N_TARG_PORT=4, AR_DATA_WIDTH=16).
// Inputs change just after the falling edge; outputs are sampled 1ns later.

module tb_axi_ar_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   arvalid_i;
    logic [N*W-1:0] ardata_i;
    logic [N-1:0]   arready_o;
    logic           arvalid_o;
    logic [W-1:0]   ardata_o;
    logic [IW-1:0]  arid_o;
    logic           arready_i;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int           m_ptr;
    bit           m_locked;
    int           m_lock_idx;
    bit           m_vq;
    logic [W-1:0] m_dq;
    int           m_idq;

    always #5 clk = ~clk;

    axi_ar_rr_arbiter #(
        .N_TARG_PORT  (N),
        .AR_DATA_WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arvalid_i(arvalid_i),
        .ardata_i (ardata_i),
        .arready_o(arready_o),
        .arvalid_o(arvalid_o),
        .ardata_o (ardata_o),
        .arid_o   (arid_o),
        .arready_i(arready_i)
    );

    function automatic logic [W-1:0] slot(input logic [N*W-1:0] d, input int t);
        return d[t*W +: W];
    endfunction

    // First requester at or after the pointer, wrapping; -1 if none.
    function automatic int rr_pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_locked = 0; m_lock_idx = 0; m_vq = 0; m_dq = '0; m_idq = 0;
    endfunction

    function automatic void model_expect(output bit ev, output logic [N-1:0] er,
                                         output int eid, output logic [W-1:0] ed);
        int g;
        g  = rr_pick(arvalid_i);
        er = '0;
`ifdef AXI_AR_ARB_OUT_REG_EN
        ev  = m_vq;
        eid = m_idq;
        ed  = m_dq;
        if ((!m_vq || arready_i) && g >= 0) er[g] = 1'b1;
`else
        if (m_locked) g = m_lock_idx;
        ev  = (g >= 0) && arvalid_i[g];
        eid = ev ? g : 0;
        ed  = ev ? slot(ardata_i, g) : '0;
        if (ev && arready_i) er[g] = 1'b1;
`endif
        if (rst) begin
            ev = 0;
            er = '0;
        end
    endfunction

    function automatic void model_update();
        int g;
        g = rr_pick(arvalid_i);
        if (rst) begin
            model_reset();
            return;
        end
`ifdef AXI_AR_ARB_OUT_REG_EN
        if (!m_vq || arready_i) begin
            if (g >= 0) begin
                m_vq = 1; m_dq = slot(ardata_i, g); m_idq = g; m_ptr = (g + 1) % N;
            end else begin
                m_vq = 0;
            end
        end
`else
        if (m_locked) g = m_lock_idx;
        if (g >= 0 && arvalid_i[g]) begin
            if (arready_i) begin
                m_ptr = (g + 1) % N; m_locked = 0;
            end else begin
                m_locked = 1; m_lock_idx = g;
            end
        end
`endif
    endfunction

    task automatic drive(input logic r, input logic [N-1:0] req, input logic rdy,
                         input logic [N*W-1:0] d);
        @(negedge clk);
        rst = r; arvalid_i = req; arready_i = rdy; ardata_i = d;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, 1'b0, '0);
        model_reset();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, '1, 1'b1, {$urandom, $urandom});
            checks++;
            if (arvalid_o !== 1'b0) begin
                failures++; $display("FAIL reset_arvalid got=%b exp=0", arvalid_o);
            end
            checks++;
            if (arready_o !== 4'b0000) begin
                failures++; $display("FAIL reset_arready got=%b exp=0000", arready_o);
            end
        end
        drive(1'b0, '1, 1'b1, {$urandom, $urandom});
`ifdef AXI_AR_ARB_OUT_REG_EN
        checks++;
        if (arvalid_o !== 1'b0) begin
            failures++; $display("FAIL rel_arvalid got=%b exp=0", arvalid_o);
        end
        checks++;
        if (arready_o !== 4'b0001) begin
            failures++; $display("FAIL rel_arready got=%b exp=0001", arready_o);
        end
        drive(1'b0, '1, 1'b1, {$urandom, $urandom});
`endif
        checks++;
        if (arvalid_o !== 1'b1) begin
            failures++; $display("FAIL rel_first_valid got=%b exp=1", arvalid_o);
        end
        checks++;
        if (arid_o !== 2'd0) begin
            failures++; $display("FAIL rel_first_id got=%0d exp=0", arid_o);
        end
    endtask

`ifdef AXI_AR_ARB_OUT_REG_EN
    task automatic test_reg_pipeline();
        logic [N*W-1:0] d;
        logic [W-1:0]   exp_d;
        exp_d = '0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            d = {$urandom, $urandom};
            drive(1'b0, '1, 1'b1, d);
            if (c == 0) begin
                checks++;
                if (arvalid_o !== 1'b0) begin
                    failures++; $display("FAIL pipe_lat_valid got=%b exp=0", arvalid_o);
                end
            end else begin
                checks++;
                if (arvalid_o !== 1'b1) begin
                    failures++; $display("FAIL pipe_valid c=%0d got=%b exp=1", c, arvalid_o);
                end
                checks++;
                if (arid_o !== 2'(c - 1)) begin
                    failures++; $display("FAIL pipe_id c=%0d got=%0d exp=%0d", c, arid_o, c - 1);
                end
                checks++;
                if (ardata_o !== exp_d) begin
                    failures++; $display("FAIL pipe_data c=%0d got=%h exp=%h", c, ardata_o, exp_d);
                end
            end
            checks++;
            if (arready_o !== 4'(1 << (c % N))) begin
                failures++; $display("FAIL pipe_ready c=%0d got=%b exp=%b", c, arready_o, 4'(1 << (c % N)));
            end
            exp_d = slot(d, c % N);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, '1, 1'b0, {$urandom, $urandom});
            checks++;
            if (arvalid_o !== 1'b1 || arid_o !== 2'd0) begin
                failures++; $display("FAIL stall_hold got=%b/%0d exp=1/0", arvalid_o, arid_o);
            end
            checks++;
            if (ardata_o !== exp_d) begin
                failures++; $display("FAIL stall_data got=%h exp=%h", ardata_o, exp_d);
            end
            checks++;
            if (arready_o !== 4'b0000) begin
                failures++; $display("FAIL stall_ready got=%b exp=0000", arready_o);
            end
        end
    endtask
`else
    task automatic test_round_robin();
        int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 4'b1111, 1'b1, {$urandom, $urandom});
            checks++;
            if (arid_o !== 2'(exp_ids[c])) begin
                failures++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, arid_o, exp_ids[c]);
            end
            checks++;
            if (arready_o !== 4'(1 << exp_ids[c])) begin
                failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, arready_o, 4'(1 << exp_ids[c]));
            end
        end
    endtask

    task automatic test_lock();
        logic [N*W-1:0] d;
        logic [W-1:0]   fixed;
        fixed = 16'hA5C3;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            d = {$urandom, $urandom};
            d[2*W +: W] = fixed;
            drive(1'b0, (c < 3) ? 4'b0100 : 4'b0101, 1'b0, d);
            checks++;
            if (arvalid_o !== 1'b1 || arid_o !== 2'd2) begin
                failures++; $display("FAIL lock_grant c=%0d got=%b/%0d exp=1/2", c, arvalid_o, arid_o);
            end
            checks++;
            if (ardata_o !== fixed) begin
                failures++; $display("FAIL lock_data c=%0d got=%h exp=%h", c, ardata_o, fixed);
            end
            checks++;
            if (arready_o !== 4'b0000) begin
                failures++; $display("FAIL lock_ready c=%0d got=%b exp=0000", c, arready_o);
            end
        end
        drive(1'b0, 4'b0101, 1'b1, d);
        checks++;
        if (arid_o !== 2'd2 || arready_o !== 4'b0100) begin
            failures++; $display("FAIL lock_release got=%0d/%b exp=2/0100", arid_o, arready_o);
        end
        drive(1'b0, 4'b0001, 1'b1, {$urandom, $urandom});
        checks++;
        if (arid_o !== 2'd0 || arready_o !== 4'b0001) begin
            failures++; $display("FAIL lock_next got=%0d/%b exp=0/0001", arid_o, arready_o);
        end
    endtask

    task automatic test_wrap();
        int exp_ids[3] = '{2, 0, 1};
        logic [N-1:0] reqs[3] = '{4'b0100, 4'b0011, 4'b0011};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, reqs[c], 1'b1, {$urandom, $urandom});
            checks++;
            if (arid_o !== 2'(exp_ids[c]) || arready_o !== 4'(1 << exp_ids[c])) begin
                failures++; $display("FAIL wrap c=%0d got=%0d/%b exp=%0d", c, arid_o, arready_o, exp_ids[c]);
            end
        end
    endtask

    task automatic test_reset_locked();
        do_reset();
        drive(1'b0, 4'b1000, 1'b0, {$urandom, $urandom});
        drive(1'b0, 4'b1000, 1'b0, ardata_i);
        checks++;
        if (arid_o !== 2'd3 || arvalid_o !== 1'b1) begin
            failures++; $display("FAIL rstlk_locked got=%0d/%b exp=3/1", arid_o, arvalid_o);
        end
        drive(1'b1, 4'b1010, 1'b0, {$urandom, $urandom});
        checks++;
        if (arvalid_o !== 1'b0 || arready_o !== 4'b0000) begin
            failures++; $display("FAIL rstlk_gate got=%b/%b exp=0/0000", arvalid_o, arready_o);
        end
        drive(1'b0, 4'b1010, 1'b1, {$urandom, $urandom});
        checks++;
        if (arid_o !== 2'd1 || arready_o !== 4'b0010) begin
            failures++; $display("FAIL rstlk_regrant got=%0d/%b exp=1/0010", arid_o, arready_o);
        end
    endtask
`endif

    task automatic test_random();
        logic [N*W-1:0] d, prev_d;
        logic [N-1:0]   req, er;
        logic           r, rdy;
        bit             ev;
        int             eid;
        logic [W-1:0]   ed;
        prev_d = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r   = ($urandom_range(0, 49) == 0);
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            d   = {$urandom, $urandom};
            rdy = ($urandom_range(0, 2) != 0);
`ifndef AXI_AR_ARB_OUT_REG_EN
            // A stalled AXI source keeps valid and payload stable.
            if (m_locked) begin
                req[m_lock_idx] = 1'b1;
                d[m_lock_idx*W +: W] = prev_d[m_lock_idx*W +: W];
            end
`endif
            drive(r, req, rdy, d);
            prev_d = d;
            model_expect(ev, er, eid, ed);
            checks++;
            if (arvalid_o !== ev) begin
                failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, arvalid_o, ev);
            end
            checks++;
            if (arready_o !== er) begin
                failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, arready_o, er);
            end
            if (ev) begin
                checks++;
                if (arid_o !== 2'(eid)) begin
                    failures++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, arid_o, eid);
                end
                checks++;
                if (ardata_o !== ed) begin
                    failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, ardata_o, ed);
                end
            end
            model_update();
        end
    endtask

    initial begin
        rst = 1'b1; arvalid_i = '0; arready_i = 1'b0; ardata_i = '0;
        model_reset();
        test_reset();
`ifdef AXI_AR_ARB_OUT_REG_EN
        test_reg_pipeline();
`else
        test_round_robin();
        test_lock();
        test_wrap();
        test_reset_locked();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "time limit");
    end

endmodule
